// File: rtl/jcsbus_seq_if.sv
// Request/response bundle between a controller and the bus-transfer sequencer.
// The requester (switches/controller) owns the request side; the sequencer drives status and display outputs.
interface jcsbus_seq_if #(
  parameter int WIDTH = 8,
  parameter int SELW  = 3
);
  logic                   START;
  logic [SELW-1:0]        SRC;
  logic [SELW-1:0]        DST;
  logic [1:0]             OP;
  logic [WIDTH-1:0]       DATA;
  logic [SELW-1:0]        RDSEL;
  logic [WIDTH-1:0]       RDDATA;
  logic [WIDTH-1:0]       BUS;
  logic [(1<<SELW)-1:0]   ENA;
  logic [(1<<SELW)-1:0]   SET;
  logic                   BUSY;
  logic                   DONE;
  logic                   ERR;
  logic                   CARRY;

  modport master (output START, SRC, DST, OP, DATA, RDSEL,
                  input  RDDATA, BUS, ENA, SET, BUSY, DONE, ERR, CARRY);
  modport slave  (input  START, SRC, DST, OP, DATA, RDSEL,
                  output RDDATA, BUS, ENA, SET, BUSY, DONE, ERR, CARRY);
endinterface

// File: rtl/jcsbus_seq.sv
// Bus-transfer sequencer: NREG general registers plus TMP/ACC on one shared bus.
// Each request runs ENA (drive bus) then SETS (latch destination), then a DONE pulse.
module jcsbus_reg #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             we,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN)  q <= '0;
    else if (we)  q <= d;
  end
endmodule

module jcsbus_seq #(
  parameter int WIDTH = 8,
  parameter int NREG  = 4,
  parameter int SELW  = 3
) (
  input  logic         CLK,
  input  logic         RESETN,
  jcsbus_seq_if.slave  bus
);
  localparam int              NSEL       = 1 << SELW;
  localparam logic [SELW-1:0] ACC_SEL    = SELW'(NREG + 1);
  localparam logic [SELW-1:0] TMP_RD     = SELW'(NREG + 2);
  localparam bit              HAS_TMP_RD = (NREG + 2) < NSEL;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ENA  = 3'd1;
  localparam logic [2:0] S_SETS = 3'd2;
  localparam logic [2:0] S_DONE = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  typedef struct packed {
    logic [SELW-1:0] src;
    logic [SELW-1:0] dst;
    logic [1:0]      op;
  } req_t;

  logic [2:0]                 state;
  req_t                       req;
  logic [NREG-1:0][WIDTH-1:0] r;
  logic [NREG-1:0]            r_we;
  logic [WIDTH-1:0]           tmp, acc, src_val, alu;
  logic                       carry, alu_c;
  logic                       active, in_sets, is_move, bad_req;

  assign active  = (state == S_ENA) || (state == S_SETS);
  assign in_sets = (state == S_SETS);
  assign is_move = (req.op == 2'b00);
  // Widened compares keep the check meaningful when ACC_SEL is the all-ones code.
  assign bad_req = ({1'b0, bus.SRC} > {1'b0, ACC_SEL}) ||
                   ((bus.OP == 2'b00) &&
                    ((bus.DST == '0) || ({1'b0, bus.DST} > {1'b0, ACC_SEL})));

  // DONE doubles as an accept slot so back-to-back requests run at one per 3 cycles.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state <= S_IDLE;
      req   <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          state <= S_IDLE;
          if (bus.START) begin
            if (bad_req) state <= S_ERR;
            else begin
              state <= S_ENA;
              req   <= '{src: bus.SRC, dst: bus.DST, op: bus.OP};
            end
          end
        end
        S_ENA:   state <= S_SETS;
        S_SETS:  state <= S_DONE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_comb begin
    src_val = '0;
    if (req.src == '0)     src_val = bus.DATA;
    if (req.src == ACC_SEL) src_val = acc;
    for (int i = 0; i < NREG; i++)
      if (req.src == SELW'(i + 1)) src_val = r[i];
  end

  always_comb begin
    alu   = acc;
    alu_c = carry;
    case (req.op)
      2'b01:   {alu_c, alu} = {1'b0, src_val} + {1'b0, tmp};
      2'b10:   alu = src_val & tmp;
      2'b11:   alu = src_val ^ tmp;
      default: ;
    endcase
  end

  for (genvar i = 0; i < NREG; i++) begin : g_reg
    assign r_we[i] = in_sets && is_move && (req.dst == SELW'(i + 1));
    jcsbus_reg #(.WIDTH(WIDTH)) u_reg (
      .CLK    (CLK),
      .RESETN (RESETN),
      .we     (r_we[i]),
      .d      (src_val),
      .q      (r[i])
    );
  end

  // A move's destination code NREG+1 names TMP; ALU ops always land in ACC.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      tmp   <= '0;
      acc   <= '0;
      carry <= 1'b0;
    end else if (in_sets) begin
      if (is_move && (req.dst == ACC_SEL)) tmp <= src_val;
      if (!is_move) begin
        acc   <= alu;
        carry <= alu_c;
      end
    end
  end

  always_comb begin
    bus.RDDATA = '0;
    if (bus.RDSEL == '0)                    bus.RDDATA = bus.DATA;
    if (bus.RDSEL == ACC_SEL)               bus.RDDATA = acc;
    if (HAS_TMP_RD && bus.RDSEL == TMP_RD)  bus.RDDATA = tmp;
    for (int i = 0; i < NREG; i++)
      if (bus.RDSEL == SELW'(i + 1)) bus.RDDATA = r[i];
  end

  assign bus.BUS   = active ? src_val : '0;
  assign bus.ENA   = active ? (NSEL'(1) << req.src) : '0;
  assign bus.SET   = !in_sets ? '0 :
                     is_move  ? (NSEL'(1) << req.dst) : (NSEL'(1) << ACC_SEL);
  assign bus.BUSY  = (state != S_IDLE);
  assign bus.DONE  = (state == S_DONE);
  assign bus.ERR   = (state == S_ERR);
  assign bus.CARRY = carry;
endmodule

// File: tb/tb_jcsbus_seq.sv
// Random and directed stimulus against a register-file model; a monitor pops expected
// results whenever DONE or ERR pulses and checks strobes, read-back and carry.
module tb_jcsbus_seq;
  localparam int W = 8, N = 4, S = 3, NS = 1 << S;

  logic CLK = 1'b0;
  logic RESETN;
  always #5 CLK = ~CLK;

  jcsbus_seq_if #(.WIDTH(W),  .SELW(S)) bi ();
  jcsbus_seq_if #(.WIDTH(16), .SELW(3)) bi2 ();

  jcsbus_seq #(.WIDTH(W),  .NREG(N), .SELW(S)) dut  (.CLK(CLK), .RESETN(RESETN), .bus(bi));
  jcsbus_seq #(.WIDTH(16), .NREG(6), .SELW(3)) dut2 (.CLK(CLK), .RESETN(RESETN), .bus(bi2));

  int total = 0, passed = 0;
  int done_cnt = 0, err_cnt = 0, legal_cnt = 0, illegal_cnt = 0;

  logic         drv_rd;
  logic [S-1:0] rdsel_drv, rdsel_mon;
  assign bi.RDSEL = drv_rd ? rdsel_drv : rdsel_mon;

  typedef struct {
    bit          err;
    logic [S-1:0]  src;
    logic [NS-1:0] setv;
    logic [W-1:0]  busv;
    logic [S-1:0]  rsel;
    logic [W-1:0]  rval;
    bit          carry;
  } exp_t;
  exp_t sbq[$];

  // Architectural model: register contents and the cycle budget until the next accept.
  logic [W-1:0] mreg [N];
  logic [W-1:0] mtmp, macc;
  bit           mcarry;
  int           since, wait_n;
  logic [S-1:0] p_src, p_dst;
  logic [1:0]   p_op;
  bit           p_live;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) $display("FAIL %s actual=%0h expected=%0h t=%0t", nm, act, exp, $time);
    else passed++;
  endtask

  function automatic logic [W-1:0] mread(input int sel);
    if (sel >= 1 && sel <= N) return mreg[sel-1];
    if (sel == N + 1)         return macc;
    if (sel == N + 2)         return mtmp;
    return '0;
  endfunction

  function automatic bit legal(input int src, input int dst, input int op);
    return (src <= N + 1) && (op != 0 || (dst >= 1 && dst <= N + 1));
  endfunction

  task automatic model_exec();
    exp_t e;
    int   sv, t;
    sv     = (p_src == 0) ? int'(bi.DATA) : int'(mread(p_src));
    e.err  = 1'b0;
    e.src  = p_src;
    e.busv = W'(sv);
    if (p_op == 2'd0) begin
      e.setv = NS'(1) << p_dst;
      if (int'(p_dst) == N + 1) begin mtmp = W'(sv); e.rsel = S'(N + 2); end
      else begin mreg[int'(p_dst) - 1] = W'(sv); e.rsel = p_dst; end
      e.rval = W'(sv);
    end else begin
      e.setv = NS'(1) << (N + 1);
      case (p_op)
        2'd1: begin
          t      = sv + int'(mtmp);
          macc   = W'(t % (1 << W));
          mcarry = (t >= (1 << W));
        end
        2'd2:    macc = W'(sv) & mtmp;
        default: macc = W'(sv) ^ mtmp;
      endcase
      e.rsel = S'(N + 1);
      e.rval = macc;
    end
    e.carry = mcarry;
    sbq.push_back(e);
  endtask

  // mode 0: random, 1: forced request, 2: hold inputs with START low, 3: random legal START high
  task automatic cycle(input int mode, input logic [S-1:0] src = '0, input logic [S-1:0] dst = '0,
                       input logic [1:0] op = '0, input logic [W-1:0] data = '0);
    exp_t e;
    bit   st;
    @(posedge CLK); #1;
    if (since < 100) since++;
    case (mode)
      0: begin
        st = ($urandom_range(0, 1) == 1);
        bi.SRC = S'($urandom); bi.DST = S'($urandom); bi.OP = 2'($urandom); bi.DATA = W'($urandom);
      end
      1: begin st = 1'b1; bi.SRC = src; bi.DST = dst; bi.OP = op; bi.DATA = data; end
      2: st = 1'b0;
      default: begin
        st = 1'b1;
        bi.SRC = S'($urandom_range(0, N + 1)); bi.DST = S'($urandom_range(1, N + 1));
        bi.OP = 2'($urandom); bi.DATA = W'($urandom);
      end
    endcase
    bi.START = st;
    if (since == 2 && p_live) begin model_exec(); p_live = 1'b0; end
    if (wait_n == 0 && st) begin
      since = 0;
      if (legal(bi.SRC, bi.DST, bi.OP)) begin
        p_src = bi.SRC; p_dst = bi.DST; p_op = bi.OP; p_live = 1'b1;
        wait_n = 2; legal_cnt++;
      end else begin
        e.err = 1'b1; e.src = '0; e.setv = '0; e.busv = '0;
        e.rsel = S'($urandom_range(1, NS - 1));
        e.rval = mread(e.rsel); e.carry = mcarry;
        sbq.push_back(e);
        wait_n = 1; illegal_cnt++;
      end
    end else if (wait_n > 0) wait_n--;
  endtask

  task automatic do_op(input logic [S-1:0] src, input logic [S-1:0] dst, input logic [1:0] op,
                       input logic [W-1:0] data);
    cycle(1, src, dst, op, data);
    cycle(2);
    cycle(2);
  endtask

  task automatic op2(input logic [2:0] src, input logic [2:0] dst, input logic [1:0] op,
                     input logic [15:0] data);
    @(posedge CLK); #1;
    bi2.START = 1'b1; bi2.SRC = src; bi2.DST = dst; bi2.OP = op; bi2.DATA = data;
    @(posedge CLK); #1;
    bi2.START = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("w16_done", 32'(bi2.DONE), 32'd1);
  endtask

  initial begin : monitor
    logic [NS-1:0] he [2], hs [2];
    logic [W-1:0]  hb [2];
    logic          hy [2];
    exp_t          e;
    rdsel_mon = '0;
    for (int i = 0; i < 2; i++) begin he[i] = '0; hs[i] = '0; hb[i] = '0; hy[i] = 1'b0; end
    forever begin
      @(negedge CLK);
      if ((bi.ENA | bi.SET) != '0)
        chk("strobe_onehot", {30'd0, $onehot0(bi.ENA), $onehot0(bi.SET)}, 32'd3);
      if (bi.DONE || bi.ERR) begin
        if (sbq.size() == 0) chk("unexpected_pulse", {30'd0, bi.DONE, bi.ERR}, 32'd0);
        else begin
          e = sbq.pop_front();
          chk("kind", {30'd0, bi.DONE, bi.ERR}, e.err ? 32'd1 : 32'd2);
          if (!e.err) begin
            done_cnt++;
            chk("ena_in_sets", 32'(he[0]), 32'(NS'(1) << e.src));
            chk("set_in_sets", 32'(hs[0]), 32'(e.setv));
            chk("bus_in_sets", 32'(hb[0]), 32'(e.busv));
            chk("ena_in_ena",  32'(he[1]), 32'(NS'(1) << e.src));
            chk("set_in_ena",  32'(hs[1]), 32'd0);
            if (e.src != '0) chk("bus_in_ena", 32'(hb[1]), 32'(e.busv));
            chk("busy_3cyc", {29'd0, hy[1], hy[0], bi.BUSY}, 32'd7);
          end else err_cnt++;
          rdsel_mon = e.rsel;
          #1;
          chk("rddata", 32'(bi.RDDATA), 32'(e.rval));
          chk("carry",  32'(bi.CARRY),  32'(e.carry));
        end
      end
      he[1] = he[0]; hs[1] = hs[0]; hb[1] = hb[0]; hy[1] = hy[0];
      he[0] = bi.ENA; hs[0] = bi.SET; hb[0] = bi.BUS; hy[0] = bi.BUSY;
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin : driver
    RESETN = 1'b0;
    bi.START = 1'b0; bi.SRC = '0; bi.DST = '0; bi.OP = '0; bi.DATA = '0;
    bi2.START = 1'b0; bi2.SRC = '0; bi2.DST = '0; bi2.OP = '0; bi2.DATA = '0; bi2.RDSEL = '0;
    drv_rd = 1'b1; rdsel_drv = '0;
    for (int i = 0; i < N; i++) mreg[i] = '0;
    mtmp = '0; macc = '0; mcarry = 1'b0;
    since = 100; wait_n = 0; p_live = 1'b0; p_src = '0; p_dst = '0; p_op = '0;

    repeat (2) @(posedge CLK); #1;
    chk("rst_busy", 32'(bi.BUSY), 32'd0);
    chk("rst_flags", {29'd0, bi.DONE, bi.ERR, bi.CARRY}, 32'd0);
    chk("rst_bus", 32'(bi.BUS), 32'd0);
    chk("rst_strobes", {bi.ENA, bi.SET}, 32'd0);
    for (int s = 1; s < NS; s++) begin
      rdsel_drv = S'(s); #1;
      chk("rst_rddata", 32'(bi.RDDATA), 32'd0);
    end
    @(negedge CLK); RESETN = 1'b1;
    drv_rd = 1'b0;

    do_op(3'd0, 3'd1, 2'd0, 8'h5A);
    do_op(3'd0, 3'd1, 2'd0, 8'hF0);
    do_op(3'd0, 3'd5, 2'd0, 8'h20);
    do_op(3'd1, 3'd0, 2'd1, 8'h00);
    do_op(3'd1, 3'd0, 2'd2, 8'h00);
    do_op(3'd7, 3'd1, 2'd0, 8'h00);
    do_op(3'd0, 3'd0, 2'd0, 8'h00);
    do_op(3'd2, 3'd2, 2'd0, 8'h00);
    do_op(3'd5, 3'd0, 2'd3, 8'h00);
    repeat (10) cycle(3);
    repeat (400) cycle(0);
    repeat (4) cycle(2);

    cycle(1, 3'd0, 3'd3, 2'd0, 8'h77);
    cycle(2);
    @(posedge CLK); #1;
    chk("abort_in_sets", 32'(bi.SET), 32'(NS'(1) << 3));
    RESETN = 1'b0; #1;
    chk("abort_busy", 32'(bi.BUSY), 32'd0);
    chk("abort_bus", 32'(bi.BUS), 32'd0);
    chk("abort_strobes", {bi.ENA, bi.SET}, 32'd0);
    for (int i = 0; i < N; i++) mreg[i] = '0;
    mtmp = '0; macc = '0; mcarry = 1'b0;
    p_live = 1'b0; wait_n = 0; since = 100; legal_cnt--;
    drv_rd = 1'b1; rdsel_drv = 3'd3; #1;
    chk("abort_r2", 32'(bi.RDDATA), 32'd0);
    @(negedge CLK); RESETN = 1'b1;
    @(posedge CLK); #1;
    chk("abort_r2_after", 32'(bi.RDDATA), 32'd0);
    chk("abort_idle", {30'd0, bi.BUSY, bi.DONE}, 32'd0);

    op2(3'd0, 3'd6, 2'd0, 16'hFFFF);
    op2(3'd0, 3'd7, 2'd0, 16'h0001);
    op2(3'd6, 3'd0, 2'd1, 16'h0000);
    bi2.RDSEL = 3'd7; #1;
    chk("w16_acc", 32'(bi2.RDDATA), 32'h0000);
    chk("w16_carry", 32'(bi2.CARRY), 32'd1);
    bi2.RDSEL = 3'd6; #1;
    chk("w16_r5", 32'(bi2.RDDATA), 32'hFFFF);

    repeat (3) @(posedge CLK);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    chk("done_count", 32'(done_cnt), 32'(legal_cnt));
    chk("err_count", 32'(err_cnt), 32'(illegal_cnt));
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
